// File: rtl/fb_pkg.sv
// Shared types and defaults for the frame-buffer pixel writer.
package fb_pkg;

    localparam int unsigned H_RES_DEF  = 640;
    localparam int unsigned V_RES_DEF  = 480;
    localparam int unsigned ADDR_W_DEF = 19;
    localparam int unsigned COLOR_W    = 24;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } fb_state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [COLOR_W-1:0]    color;
    } fb_entry_t;

endpackage

// File: rtl/fb_fifo.sv
// Synchronous FIFO of frame-buffer entries; a push on full succeeds when a pop happens too.
module fb_fifo
    import fb_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic      Clk,
    input  logic      Reset,
    input  logic      push,
    input  logic      pop,
    input  fb_entry_t din,
    output fb_entry_t dout,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    fb_entry_t       mem_q [DEPTH];
    logic [PtrW:0]   wr_ptr_q;
    logic [PtrW:0]   rd_ptr_q;
    logic            do_push;
    logic            do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q[PtrW-1:0]];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= din;
    end

endmodule

// File: rtl/fb_pixel_writer.sv
// Buffers the rasteriser pixel stream and writes it to a linear frame buffer.
// Optional FB_SKIP_ZERO_EN: black pixels are not written.
module fb_pixel_writer
    import fb_pkg::*;
#(
    parameter int unsigned H_RES  = H_RES_DEF,
    parameter int unsigned V_RES  = V_RES_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [10:0]       pix_x,
    input  logic [10:0]       pix_y,
    input  logic [23:0]       pix_color,
    input  logic              frame_done_in,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [23:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              fb_done,
    output logic              overflow
);

    fb_state_t         state_q, state_d;
    fb_entry_t         in_entry;
    fb_entry_t         fifo_dout;
    fb_entry_t         out_q;
    logic              mem_we_q;
    logic              overflow_q;
    logic [ADDR_W-1:0] lin_addr;
    logic              in_range;
    logic              is_skip;
    logic              accept;
    logic              stage_load;
    logic              bypass;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              drop;

    assign lin_addr = ADDR_W'(32'(pix_y) * H_RES + 32'(pix_x));
    assign in_range = (32'(pix_x) < H_RES) && (32'(pix_y) < V_RES);

`ifdef FB_SKIP_ZERO_EN
    assign is_skip = (pix_color == 24'h000000);
`else
    assign is_skip = 1'b0;
`endif

    assign accept         = (state_q == StRun) && pix_valid && in_range && !is_skip;
    assign in_entry.addr  = ADDR_W_DEF'(lin_addr);
    assign in_entry.color = pix_color;

    // The output stage refills when empty or when its write retires this cycle.
    // With an empty FIFO the incoming pixel goes straight to the stage.
    assign stage_load = !mem_we_q || mem_ready;
    assign fifo_pop   = stage_load && !fifo_empty;
    assign bypass     = stage_load && fifo_empty && accept;
    assign fifo_push  = accept && !bypass;
    assign drop       = fifo_push && fifo_full && !fifo_pop;

    fb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (in_entry),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mem_we_q <= 1'b0;
            out_q    <= '0;
        end else if (stage_load) begin
            if (fifo_pop) begin
                mem_we_q <= 1'b1;
                out_q    <= fifo_dout;
            end else if (bypass) begin
                mem_we_q <= 1'b1;
                out_q    <= in_entry;
            end else begin
                mem_we_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            overflow_q <= 1'b0;
        end else if ((state_q == StIdle) && frame_start) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (frame_start) state_d = StRun;
            StRun:   if (frame_done_in) state_d = StDrain;
            StDrain: if (fifo_empty && (!mem_we_q || mem_ready)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = ADDR_W'(out_q.addr);
    assign mem_wdata = out_q.color;
    assign busy      = (state_q == StRun) || (state_q == StDrain);
    assign fb_done   = (state_q == StDone);
    assign overflow  = overflow_q;

endmodule
